// File: rtl/req_gnt_if.sv
// req_gnt_if: request/grant bundle between the requesters and req_gnt_scheduler.
//   req            level request lines, one per requester (0->1 = one request)
//   res_ready      shared resource can accept a grant this cycle
//   req_tag_*      one-cycle report of an entry entering the arrival FIFO
//   gnt, gnt_*     one-cycle grant pulse with requester id and sequence tag
//   pending_cnt    arrival-FIFO occupancy
//   dup_err        sticky: a request re-rose while still latched
//   timeout        sticky: head-of-queue wait limit exceeded
// Modports: slave = scheduler side, master = requester/testbench side.
interface req_gnt_if #(
  parameter int NUM_REQ = 4,
  parameter int QDEPTH  = 8,
  parameter int SEQW    = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(QDEPTH) + 1;

  logic [NUM_REQ-1:0] req;
  logic               res_ready;
  logic               req_tag_valid;
  logic [IDW-1:0]     req_tag_id;
  logic [SEQW-1:0]    req_tag;
  logic               gnt;
  logic [IDW-1:0]     gnt_id;
  logic [SEQW-1:0]    gnt_tag;
  logic [CW-1:0]      pending_cnt;
  logic               dup_err;
  logic               timeout;

  modport slave (
    input  req, res_ready,
    output req_tag_valid, req_tag_id, req_tag,
           gnt, gnt_id, gnt_tag, pending_cnt, dup_err, timeout
  );

  modport master (
    output req, res_ready,
    input  req_tag_valid, req_tag_id, req_tag,
           gnt, gnt_id, gnt_tag, pending_cnt, dup_err, timeout
  );
endinterface

// File: rtl/req_gnt_scheduler.sv
// req_gnt_scheduler: central request/grant scheduler for one shared resource.
// Rising edges on req[] are latched in a pending mask, moved one per cycle
// (lowest index first) into an arrival-order FIFO with a sequence tag, and
// granted in FIFO order as single-cycle gnt pulses spaced MIN_GAP+2 cycles
// apart, only while res_ready is high.
// Ports:
//   clk   posedge clock
//   rst   asynchronous, active-high reset
//   bus   req_gnt_if.slave (req, res_ready in; tag report, grant,
//         pending_cnt, dup_err, timeout out)
// Optional feature: define REQ_TIMEOUT_EN to enable the head-of-queue age
// counter that sets the sticky timeout flag after TIMEOUT cycles of waiting.
module req_gnt_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int QDEPTH  = 8,
  parameter int MIN_GAP = 3,
  parameter int SEQW    = 4,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  req_gnt_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(QDEPTH);
  localparam int CW  = AW + 1;
  localparam int GW  = $clog2(MIN_GAP + 1);

  // Tags must stay unique across everything that can be outstanding at once.
  generate
    if ((QDEPTH + NUM_REQ > (1 << SEQW)) || (NUM_REQ < 2) || (NUM_REQ > 16) ||
        (QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0) || (MIN_GAP < 1) ||
        (TIMEOUT < 1)) begin : g_param_chk
      $error("req_gnt_scheduler: illegal parameters (need QDEPTH+NUM_REQ <= 2**SEQW, QDEPTH pow2)");
    end
  endgenerate

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [SEQW-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  // Request capture
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] sel_mask;
  logic [NUM_REQ-1:0] pend_nxt;
  logic [IDW-1:0]     sel_id;
  logic               dup_err_q;

  // Arrival FIFO
  entry_t             mem [QDEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [SEQW-1:0]    seq;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             head;

  // Tag report
  logic               req_tag_valid_q;
  logic [IDW-1:0]     req_tag_id_q;
  logic [SEQW-1:0]    req_tag_q;

  // Grant FSM
  state_t             state, state_nxt;
  logic [GW-1:0]      gap_cnt, gap_nxt;
  logic               gnt_q, gnt_nxt;
  logic [IDW-1:0]     gnt_id_q, gnt_id_nxt;
  logic [SEQW-1:0]    gnt_tag_q, gnt_tag_nxt;

  assign rise  = bus.req & ~req_q;
  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign pop   = (state == S_IDLE) && !empty && bus.res_ready;
  // A full FIFO still accepts an entry on the cycle the head leaves.
  assign push  = (|pend) && (!full || pop);

  // Lowest pending index wins the single enqueue slot of this cycle.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    sel_id   = '0;
    sel_mask = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_id   = IDW'(i);
        sel_mask = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  // A rise on a still-pending line merges into that entry (pend stays a single bit).
  assign pend_nxt = (pend | rise) & ~(push ? sel_mask : '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      pend      <= '0;
      dup_err_q <= 1'b0;
    end else begin
      req_q <= bus.req;
      pend  <= pend_nxt;
      if (|(rise & pend)) dup_err_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: sel_id, tag: seq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      seq             <= '0;
      req_tag_valid_q <= 1'b0;
      req_tag_id_q    <= '0;
      req_tag_q       <= '0;
    end else begin
      req_tag_valid_q <= push;
      if (push) begin
        wr_ptr       <= wr_ptr + AW'(1);
        seq          <= seq + SEQW'(1);
        req_tag_id_q <= sel_id;
        req_tag_q    <= seq;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Grant FSM: IDLE pops and raises gnt, GRANT drops it and loads the gap,
  // GAP counts down so gnt rising edges are MIN_GAP+2 cycles apart.
  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    gnt_nxt     = 1'b0;
    gnt_id_nxt  = gnt_id_q;
    gnt_tag_nxt = gnt_tag_q;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_nxt   = S_GRANT;
          gnt_nxt     = 1'b1;
          gnt_id_nxt  = head.id;
          gnt_tag_nxt = head.tag;
        end
      end
      S_GRANT: begin
        state_nxt = S_GAP;
        gap_nxt   = GW'(MIN_GAP);
      end
      S_GAP: begin
        gap_nxt = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      gnt_q     <= 1'b0;
      gnt_id_q  <= '0;
      gnt_tag_q <= '0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
      gnt_tag_q <= gnt_tag_nxt;
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] age;
  logic          timeout_q;

  // Age restarts on every pop and stays 0 while empty, so it measures how
  // long the current head has waited; it saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop || empty)            age <= '0;
      else if (age != TW'(TIMEOUT)) age <= age + TW'(1);
      if (age == TW'(TIMEOUT))     timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.req_tag_valid = req_tag_valid_q;
  assign bus.req_tag_id    = req_tag_id_q;
  assign bus.req_tag       = req_tag_q;
  assign bus.gnt           = gnt_q;
  assign bus.gnt_id        = gnt_id_q;
  assign bus.gnt_tag       = gnt_tag_q;
  assign bus.pending_cnt   = count;
  assign bus.dup_err       = dup_err_q;
endmodule

// File: doc/req_gnt_scheduler.md
Name: req_gnt_scheduler

Overview:
- Central request/grant scheduler for a shared resource used by NUM_REQ requesters.
- Detects rising edges on per-requester req lines and queues them in arrival order.
- Issues single-cycle gnt pulses, each tagged with requester ID and a sequence tag, so downstream checkers can pair each grant with its originating request even when several requests are outstanding.
- Enforces a minimum gap between grants and honours a resource-ready input.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- QDEPTH, 8, arrival-order FIFO depth (power of 2)
- MIN_GAP, 3, idle cycles forced after each gnt pulse (>=1)
- SEQW, 4, sequence tag width; tag wraps mod 2^SEQW
- TIMEOUT, 16, head-of-queue wait limit in cycles (optional feature only)

Ports:
- clk  in  1  sole clock, posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request lines; a 0->1 transition is one request
- res_ready  in  1  resource can accept a grant this cycle
- req_tag_valid  out  1  pulse: a request entered the FIFO this cycle
- req_tag_id  out  $clog2(NUM_REQ)  requester of the enqueued entry
- req_tag  out  SEQW  sequence tag assigned to the enqueued entry
- gnt  out  1  single-cycle grant pulse
- gnt_id  out  $clog2(NUM_REQ)  requester granted; valid only when gnt=1
- gnt_tag  out  SEQW  tag of the granted entry; valid only when gnt=1
- pending_cnt  out  $clog2(QDEPTH)+1  FIFO occupancy
- dup_err  out  1  sticky: a requester re-rose while its request was still latched
- timeout  out  1  sticky: head-of-queue timeout (optional feature)

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; req_q=0, pend mask=0, FIFO empty, seq counter=0, FSM=IDLE, gap counter=0.
- Reset mid-operation discards all pending and queued requests. A gnt in flight drops immediately.
- Edge detect: rise[i] = req[i] & ~req_q[i]; req_q <= req every cycle.
- Latch: rise[i] sets pend[i] at the same edge.
- If pend[i] is already 1 when rise[i] occurs: set dup_err; the request is merged, not counted twice.
- Enqueue: each edge, if pend!=0 and FIFO not full:
  - the lowest set index moves to the FIFO with tag = seq, and seq increments;
  - req_tag_valid/id/tag are registered the same edge;
  - pend bit clears.
- Enqueue is one per cycle; simultaneous rises drain lowest index first.
- FIFO full: pend bits hold and no request is lost. Simultaneous push and pop is allowed when full.
- A requester may hold multiple FIFO entries (re-rise after its pend bit cleared).
- FSM:
  - IDLE: if FIFO non-empty and res_ready, go to GRANT. gnt<=1 and gnt_id/gnt_tag<=head are registered, and the entry pops.
  - GRANT (1 cycle): gnt<=0 and gap counter<=MIN_GAP, go to GAP.
  - GAP: decrement the gap counter; at 0 go to IDLE.
- res_ready low holds the FSM in IDLE; it has no effect in GRANT or GAP.
- Grant spacing: the minimum from gnt rising to the next gnt rising is MIN_GAP+2 cycles.
- Minimum latency with an empty system and res_ready=1:
  - rise sampled at edge E0, enqueue at E1, gnt registered at E2;
  - gnt is first sampled high at E3.
- Grants are strictly FIFO order: gnt_tag sequence equals req_tag sequence, mod 2^SEQW.
- Tags never alias while pending, because QDEPTH+NUM_REQ <= 2^SEQW is required (elaboration-time $error otherwise).
- pending_cnt: FIFO count only; pend-mask entries are excluded.

Optional Feature:
- Macro REQ_TIMEOUT_EN.
- Defined:
  - an age counter resets on each pop or when the FIFO becomes non-empty, and increments while the FIFO is non-empty and the head is not popped;
  - when age reaches TIMEOUT, timeout sets (sticky until rst);
  - no change to grant order.
- Undefined: no counter; timeout tied 0.

Test Plan:
- Single request: req[0] rises once, res_ready=1 -> req_tag_valid with id 0, tag 0; one gnt pulse with gnt_id=0, gnt_tag=0, 2 edges after the rise; pending_cnt returns to 0.
- Overlapping requests: req[1] rises, 3 cycles later req[2] rises -> two grants in order (id1 tag0, id2 tag1), spaced >= MIN_GAP+2=5 cycles.
- Simultaneous rises: req=4'b1011 in one cycle -> enqueue order ids 0,1,3 on consecutive cycles with tags 0,1,2; grants in the same order.
- Backpressure: res_ready=0 for 10 cycles with 3 queued -> no gnt, pending_cnt=3; release -> 3 grants in order. With REQ_TIMEOUT_EN and TIMEOUT=8, timeout=1.
- Full and duplicate: 9 requests with QDEPTH=8 and res_ready=0 -> pending_cnt=8, ninth held in pend and enqueued after the first pop. Re-rise of a requester while its pend bit is set -> dup_err=1.
- Reset mid-operation: assert rst during GAP with 2 queued -> gnt, pending_cnt and seq all 0 immediately; no stale grants after release.
